imem_fetch_arbiter: RTL and testbench

- Shares the single instruction-memory read port between NUM_CORES cores.
- Round-robin arbitration; one fixed-latency read is sequenced per grant.
- On completion, delivers the fetched word and a one-cycle IR write strobe to the winning core's instruction register.
- Sits between the per-core control units and the instruction memory.

---
 rtl/imem_arb_pkg.sv | 19 +
 rtl/imem_fetch_arbiter_rr_picker.sv | 46 ++++
 rtl/imem_fetch_arbiter.sv | 144 ++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and sizing helpers for the instruction-fetch arbiter
package imem_arb_pkg;

  // Fetch sequencer states: arbitrate, strobe the memory, wait out its latency, write the IR.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } arb_state_t;

  localparam int DEFAULT_MEM_LAT = 2;

  // Latency counter width: must hold the value MEM_LAT itself.
  function automatic int lat_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_rr_picker.sv
// rtl/imem_fetch_arbiter_rr_picker.sv - winner selection; IMEM_ARB_FIXED_PRIO_EN selects fixed priority
module rr_picker #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

`ifdef IMEM_ARB_FIXED_PRIO_EN
  // The pointer has no meaning when the lowest index always wins.
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Lowest-index asserted request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end
`else
  // First asserted request scanning upward from rr_ptr, wrapping at NUM_CORES.
  always_comb begin
    int c;
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_CORES) c = c - NUM_CORES;
      if (!valid && req[c[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - shares one instruction-memory read port among cores; IMEM_ARB_FIXED_PRIO_EN selects fixed priority
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = DEFAULT_MEM_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_data,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        ir_wr,
  output logic [DATA_W-1:0]           ir_data,
  output logic                        busy
);

  localparam int CNT_W = lat_cnt_w(MEM_LAT);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  arb_state_t               state_q, state_d;
  logic [NUM_CORES-1:0]     gnt_q, gnt_d;
  logic [NUM_CORES-1:0]     ir_wr_q, ir_wr_d;
  logic                     mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         win_q, win_d;
  logic                     busy_q, busy_d;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_valid;

`ifdef IMEM_ARB_FIXED_PRIO_EN
  rr_picker #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_picker (
    .req    (req),
    .rr_ptr ('0),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );
`else
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;

  rr_picker #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );
`endif

  // Next-state and next-output values; every output is registered from these.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ir_wr_d  = '0;
    mem_rd_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
`ifndef IMEM_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // The address is latched here so later req_addr changes cannot disturb the fetch.
        if (pick_valid) begin
          win_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          mem_rd_d        = 1'b1;
          addr_d          = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          data_d         = mem_data;
          ir_wr_d[win_q] = 1'b1;
          state_d        = WRITE;
        end
      end
      WRITE: begin
        gnt_d   = '0;
        state_d = IDLE;
`ifndef IMEM_ARB_FIXED_PRIO_EN
        if (win_q == IDX_W'(NUM_CORES - 1)) rr_ptr_d = '0;
        else                                rr_ptr_d = win_q + IDX_W'(1);
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any fetch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ir_wr_q  <= '0;
      mem_rd_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      win_q    <= '0;
      busy_q   <= 1'b0;
`ifndef IMEM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ir_wr_q  <= ir_wr_d;
      mem_rd_q <= mem_rd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      busy_q   <= busy_d;
`ifndef IMEM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = addr_q;
  assign gnt      = gnt_q;
  assign ir_wr    = ir_wr_q;
  assign ir_data  = data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - scoreboard bench for imem_fetch_arbiter; honours IMEM_ARB_FIXED_PRIO_EN
module tb_imem_fetch_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int FAR = 32'h3fffffff;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [DW-1:0]   mem_data;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ir_wr;
  logic [DW-1:0]   ir_data;
  logic            busy;

  imem_fetch_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .gnt      (gnt),
    .ir_wr    (ir_wr),
    .ir_data  (ir_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          core;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } mrsp_t;

  ev_t           exp_rd[$];
  ev_t           exp_wr[$];
  mrsp_t         mpend[$];
  logic [DW-1:0] mem [256];

  int  cyc = 0;
  int  n_total = 0;
  int  n_pass = 0;
  bit  chk_en = 1'b0;
  int  ptr = 0;
  int  free_at = 0;
  int  own_core = 0;
  int  own_s = FAR;
  int  own_e = 0;
  int  pa_cyc = FAR;
  int  pd_cyc = FAR;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference arbitration rule.
  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef IMEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: data appears exactly LAT cycles after the strobe, noise otherwise.
  initial begin
    mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mpend.size() > 0 && mpend[0].due == cyc) mem_data = mpend.pop_front().data;
      else mem_data = DW'($urandom);
    end
  end

  // Monitor and reference model.
  always @(negedge clk) begin : mon
    ev_t           e;
    mrsp_t         m;
    int            w;
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    if (chk_en) begin
      if (mem_rd === 1'b1) begin
        m.due  = cyc + LAT;
        m.data = mem[mem_addr];
        mpend.push_back(m);
        if (exp_rd.size() == 0) chk("mem_rd_spurious", 32'(mem_rd), 32'd0);
        else begin
          e = exp_rd.pop_front();
          chk("mem_rd_cycle", cyc, e.cyc);
          chk("mem_addr_on_rd", 32'(mem_addr), 32'(e.addr));
        end
      end else if (exp_rd.size() > 0 && exp_rd[0].cyc <= cyc) begin
        e = exp_rd.pop_front();
        chk("mem_rd_missing", 32'(mem_rd), 32'd1);
      end
      if (ir_wr !== '0) begin
        if (exp_wr.size() == 0) chk("ir_wr_spurious", 32'(ir_wr), 32'd0);
        else begin
          e = exp_wr.pop_front();
          chk("ir_wr_cycle", cyc, e.cyc);
          chk("ir_wr_core", 32'(ir_wr), 32'(onehot(e.core)));
          chk("ir_data_on_wr", 32'(ir_data), 32'(e.data));
        end
      end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
        e = exp_wr.pop_front();
        chk("ir_wr_missing", 32'(ir_wr), 32'(onehot(e.core)));
      end
      if (cyc >= pa_cyc) cur_addr = pend_addr;
      if (cyc >= pd_cyc) cur_data = pend_data;
      eg = (cyc >= own_s && cyc <= own_e) ? onehot(own_core) : '0;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("busy", 32'(busy), 32'(eg != '0));
      chk("mem_addr_hold", 32'(mem_addr), 32'(cur_addr));
      chk("ir_data_hold", 32'(ir_data), 32'(cur_data));
    end
    if (rst === 1'b1) begin
      exp_rd.delete();
      exp_wr.delete();
      mpend.delete();
      ptr      = 0;
      free_at  = cyc + 1;
      own_s    = FAR;
      own_e    = 0;
      pa_cyc   = FAR;
      pd_cyc   = FAR;
      cur_addr = '0;
      cur_data = '0;
      chk_en   = 1'b1;
    end else if (chk_en && cyc >= free_at && req != '0) begin
      w      = pick(req, ptr);
      a      = req_addr[w*AW +: AW];
      e.core = w;
      e.addr = a;
      e.data = mem[a];
      e.cyc  = cyc + 1;
      exp_rd.push_back(e);
      e.cyc  = cyc + 2 + LAT;
      exp_wr.push_back(e);
      own_core  = w;
      own_s     = cyc + 1;
      own_e     = cyc + 2 + LAT;
      free_at   = cyc + 3 + LAT;
      pend_addr = a;
      pa_cyc    = cyc + 1;
      pend_data = mem[a];
      pd_cyc    = cyc + 2 + LAT;
      ptr       = (w + 1) % N;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int c);
    for (int k = 0; k < 30; k++) begin
      step();
      if (ir_wr[c] === 1'b1) break;
    end
    chk("wait_ir_wr", 32'(ir_wr[c]), 32'd1);
  endtask

  task automatic wait_rd();
    for (int k = 0; k < 12; k++) begin
      step();
      if (mem_rd === 1'b1) break;
    end
    chk("wait_mem_rd", 32'(mem_rd), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h3C] = 16'hA5F0;
    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Single request from core 2.
    req = 4'b0100;
    req_addr[2*AW +: AW] = 8'h3C;
    wait_wr(2);
    req = '0;
    repeat (4) step();

    // All cores requesting from a fresh pointer.
    rst = 1'b1;
    step();
    rst      = 1'b0;
    req_addr = {8'h40, 8'h30, 8'h20, 8'h10};
    req      = 4'hF;
    repeat (25) step();
    req = '0;
    repeat (8) step();

    // Requester withdraws during the wait.
    req = 4'b0010;
    wait_rd();
    step();
    req = '0;
    repeat (8) step();

    // Reset in the middle of a fetch, then a contested request.
    req = 4'b0100;
    wait_rd();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1001;
    wait_wr(0);
    req = '0;
    repeat (8) step();

    // Address changes after sampling.
    req_addr[0 +: AW] = 8'h11;
    req = 4'b0001;
    step();
    step();
    req_addr[0 +: AW] = 8'h22;
    wait_wr(0);
    req = '0;
    repeat (8) step();

    // Two cores held continuously.
    req = 4'b1001;
    repeat (40) step();
    req = '0;
    repeat (8) step();

    // Random traffic.
    for (int t = 0; t < 2500; t++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(399) == 0) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && ir_wr[i] === 1'b1) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom);
        end else if (req[i] && $urandom_range(39) == 0) req[i] = 1'b0;
        if ($urandom_range(4) == 0) req_addr[i*AW +: AW] = AW'($urandom);
      end
    end

    req = '0;
    rst = 1'b0;
    repeat (12) step();
    chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
